// File: rtl/wbrr_arbiter.sv
// wbrr_arbiter
// Two-master, one-slave pipelined Wishbone arbiter. Ownership is granted
// round-robin at bus-cycle boundaries. ACK/ERR go back to the owning master
// only. The arbiter counts outstanding requests and aborts a hung cycle with
// an ERR to the owner once TIMEOUT cycles pass with no response.
//
// Ports
//   i_wb_clk, i_reset_n         clock, asynchronous active-low reset
//   i_a_* / o_a_*               master A request in / response out
//   i_b_* / o_b_*               master B request in / response out
//   o_cyc ... o_sel             forwarded request to the slave
//   i_stall, i_ack, i_err,
//   i_data                      slave responses
//
// Parameters
//   AW, DW   address and data widths; the select width is DW/8
//   LGOUT    outstanding-counter width; at most 2^LGOUT-1 requests in flight
//   TIMEOUT  response-free cycles tolerated before an abort (must be >= 2)
module wbrr_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int LGOUT   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic            i_wb_clk,
    input  logic            i_reset_n,
    input  logic            i_a_cyc,
    input  logic            i_a_stb,
    input  logic            i_a_we,
    input  logic [AW-1:0]   i_a_addr,
    input  logic [DW-1:0]   i_a_data,
    input  logic [DW/8-1:0] i_a_sel,
    output logic            o_a_stall,
    output logic            o_a_ack,
    output logic            o_a_err,
    output logic [DW-1:0]   o_a_data,
    input  logic            i_b_cyc,
    input  logic            i_b_stb,
    input  logic            i_b_we,
    input  logic [AW-1:0]   i_b_addr,
    input  logic [DW-1:0]   i_b_data,
    input  logic [DW/8-1:0] i_b_sel,
    output logic            o_b_stall,
    output logic            o_b_ack,
    output logic            o_b_err,
    output logic [DW-1:0]   o_b_data,
    output logic            o_cyc,
    output logic            o_stb,
    output logic            o_we,
    output logic [AW-1:0]   o_addr,
    output logic [DW-1:0]   o_data,
    output logic [DW/8-1:0] o_sel,
    input  logic            i_stall,
    input  logic            i_ack,
    input  logic            i_err,
    input  logic [DW-1:0]   i_data
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [LGOUT-1:0] OUT_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2,
        ABORT = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             last_b;       // most recent grant went to B
    logic [LGOUT-1:0] outstanding;
    logic [TW-1:0]    timer;

    logic req_a, req_b;
    logic own, own_cyc, own_stb;
    logic full, resp, retire, issue, timeout;

    assign req_a   = i_a_cyc && i_a_stb;
    assign req_b   = i_b_cyc && i_b_stb;
    assign own     = (state == OWN_A) || (state == OWN_B);

    // last_b names the current owner in OWN_x, and the aborted owner in ABORT.
    assign own_cyc = last_b ? i_b_cyc : i_a_cyc;
    assign own_stb = last_b ? i_b_stb : i_a_stb;

    assign full    = (outstanding == OUT_MAX);
    assign resp    = i_ack || i_err;
    assign retire  = resp && (outstanding != '0);   // a response at zero is ignored
    assign issue   = own && own_stb && !full && !i_stall;

    // A response in the final cycle counts as an answer, so no abort then.
    assign timeout = own && own_cyc && !resp && (outstanding != '0) &&
                     (timer == TIMER_LAST);

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge i_wb_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state  <= IDLE;
            last_b <= 1'b1;                 // A wins the first tie
        end else begin
            state <= state_nx;
            if (state_nx == OWN_A)      last_b <= 1'b0;
            else if (state_nx == OWN_B) last_b <= 1'b1;
        end
    end

    // Next-state logic.
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and infers a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req_a && (!req_b || last_b)) state_nx = OWN_A;
                else if (req_b)                  state_nx = OWN_B;
            end
            OWN_A, OWN_B: begin
                if (!own_cyc)     state_nx = IDLE;
                else if (timeout) state_nx = ABORT;
            end
            ABORT: begin
                if (!own_cyc) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outstanding-request counter and response timer. Both are cleared on
    // release or abort and held at zero outside ownership.
    always_ff @(posedge i_wb_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            outstanding <= '0;
            timer       <= '0;
        end else if (!own || !own_cyc || timeout) begin
            outstanding <= '0;
            timer       <= '0;
        end else begin
            if (issue && !retire)      outstanding <= outstanding + LGOUT'(1);
            else if (!issue && retire) outstanding <= outstanding - LGOUT'(1);
            timer <= ((outstanding == '0) || resp) ? '0 : timer + TW'(1);
        end
    end

    // Slave-side request mux; only meaningful while o_stb is high.
    assign o_we     = last_b ? i_b_we   : i_a_we;
    assign o_addr   = last_b ? i_b_addr : i_a_addr;
    assign o_data   = last_b ? i_b_data : i_a_data;
    assign o_sel    = last_b ? i_b_sel  : i_a_sel;
    assign o_a_data = i_data;
    assign o_b_data = i_data;

    // Output logic. IDLE and ABORT keep the bus idle and both masters stalled.
    always_comb begin
        o_cyc     = 1'b0;
        o_stb     = 1'b0;
        o_a_stall = 1'b1;
        o_b_stall = 1'b1;
        o_a_ack   = 1'b0;
        o_a_err   = 1'b0;
        o_b_ack   = 1'b0;
        o_b_err   = 1'b0;
        case (state)
            OWN_A: begin
                o_cyc     = i_a_cyc;
                o_stb     = i_a_stb && !full;
                o_a_stall = i_stall || full;
                o_a_ack   = i_ack;
                o_a_err   = i_err || timeout;
            end
            OWN_B: begin
                o_cyc     = i_b_cyc;
                o_stb     = i_b_stb && !full;
                o_b_stall = i_stall || full;
                o_b_ack   = i_ack;
                o_b_err   = i_err || timeout;
            end
            default: ;
        endcase
    end

endmodule
